// File: rtl/life_gen_engine.sv
// life_gen_engine: parametrised Game-of-Life engine with serial stepping and LED scan.
// Optional build macro LIFE_TORUS_EN: neighbour coordinates wrap (toroidal grid).
module life_gen_engine #(
  parameter int         X       = 8,
  parameter int         Y       = 8,
  parameter int         LOG2X   = 3,
  parameter int         LOG2Y   = 3,
  parameter logic [8:0] BIRTH   = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100,
  parameter int         TICK_W  = 16,
  parameter int         SCAN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_nxt,
  input  logic              key_run,
  input  logic              key_flip,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic [TICK_W-1:0] rate,
  output logic [X-1:0]      row,
  output logic [Y-1:0]      col,
  output logic              busy,
  output logic              stable,
  output logic [15:0]       gen_cnt
);
  localparam int N  = X * Y;
  localparam int IW = LOG2X + LOG2Y;
  localparam logic [LOG2X-1:0] XM = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YM = LOG2Y'(Y - 1);
  localparam logic [IW-1:0]    NM = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [6:0]        key_in, key_q, key_d, press;
  logic              nxt_p, run_p, flip_p, up_p, down_p, left_p, right_p;
  logic [N-1:0]      grid, shadow;
  logic [LOG2X-1:0]  cx, calc_x;
  logic [LOG2Y-1:0]  cy, calc_y, line;
  logic [IW-1:0]     calc_i, cur_i;
  logic              calc_last, run, step_pend, tick, new_cell, idle;
  logic [TICK_W-1:0] presc;
  logic [3:0]        nsum;
  int                nx, ny;
  logic [SCAN_W-1:0] scan_cnt;
  logic [4:0]        frame;
  logic [X-1:0]      row_nxt;

  assign key_in = {key_right, key_left, key_down, key_up,
                   key_flip, key_run, key_nxt};
  assign press  = key_q & ~key_d;
  assign {right_p, left_p, down_p, up_p,
          flip_p, run_p, nxt_p} = press;

  assign idle      = (state == IDLE);
  assign busy      = ~idle;
  assign calc_last = (calc_i == NM);
  assign cur_i     = IW'(int'(cy) * X + int'(cx));
  assign tick      = run && idle && !step_pend && (presc == rate);
  assign new_cell  = grid[calc_i] ? SURVIVE[nsum] : BIRTH[nsum];

  // Neighbour count of the cell under calculation, from the committed grid.
  always_comb begin
    nsum = '0;
    nx = 0;
    ny = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(calc_x) + dx;
        ny = int'(calc_y) + dy;
`ifdef LIFE_TORUS_EN
        if (nx < 0) nx = X - 1;
        else if (nx >= X) nx = 0;
        if (ny < 0) ny = Y - 1;
        else if (ny >= Y) ny = 0;
        if (!(dx == 0 && dy == 0))
          nsum = nsum + {3'b000, grid[IW'(ny * X + nx)]};
`else
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < X &&
            ny >= 0 && ny < Y)
          nsum = nsum + {3'b000, grid[IW'(ny * X + nx)]};
`endif
      end
    end
  end

  // Generation FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Generation FSM next state; a flip press holds off a pending step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (step_pend && !flip_p) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Key history, cursor, run flag, step request and auto-run prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= '0;
      key_d     <= '0;
      cx        <= '0;
      cy        <= '0;
      run       <= 1'b0;
      step_pend <= 1'b0;
      presc     <= '0;
    end else begin
      key_q <= key_in;
      key_d <= key_q;
      if (right_p)     cx <= (cx == XM) ? '0 : cx + LOG2X'(1);
      else if (left_p) cx <= (cx == '0) ? XM : cx - LOG2X'(1);
      if (down_p)      cy <= (cy == YM) ? '0 : cy + LOG2Y'(1);
      else if (up_p)   cy <= (cy == '0) ? YM : cy - LOG2Y'(1);
      if (state == COMMIT && shadow == grid) run <= 1'b0;
      else if (run_p)                        run <= ~run;
      if (idle) begin
        if (state_nxt == CALC)   step_pend <= 1'b0;
        else if (nxt_p || tick)  step_pend <= 1'b1;
      end
      if (run && idle && !step_pend)
        presc <= (presc == rate) ? '0 : presc + TICK_W'(1);
    end
  end

  // Grid editing, serial next-generation calculation and atomic commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grid    <= '0;
      shadow  <= '0;
      calc_x  <= '0;
      calc_y  <= '0;
      calc_i  <= '0;
      gen_cnt <= '0;
      stable  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (flip_p) grid[cur_i] <= ~grid[cur_i];
        CALC: begin
          shadow[calc_i] <= new_cell;
          if (calc_last) begin
            calc_x <= '0;
            calc_y <= '0;
            calc_i <= '0;
          end else begin
            calc_i <= calc_i + IW'(1);
            if (calc_x == XM) begin
              calc_x <= '0;
              calc_y <= calc_y + LOG2Y'(1);
            end else begin
              calc_x <= calc_x + LOG2X'(1);
            end
          end
        end
        COMMIT: begin
          grid    <= shadow;
          gen_cnt <= gen_cnt + 16'd1;
          stable  <= (shadow == grid);
        end
        default: ;
      endcase
    end
  end

  // Line data of the scanned line with the blinking cursor overlay.
  always_comb begin
    row_nxt = '0;
    for (int x = 0; x < X; x++)
      row_nxt[x] = grid[IW'(int'(line) * X + x)];
    if (line == cy) row_nxt[cx] = row_nxt[cx] ^ frame[4];
  end

  // Multiplexed display scan with registered row/col drivers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      line     <= '0;
      frame    <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      if (&scan_cnt) begin
        if (line == YM) begin
          line  <= '0;
          frame <= frame + 5'd1;
        end else begin
          line <= line + LOG2Y'(1);
        end
      end
      col <= Y'(1) << line;
      row <= row_nxt;
    end
  end

endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: scoreboard bench for life_gen_engine.
// Grid contents are read back through the row/col scan.
`timescale 1ns/1ps
module tb_life_gen_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_nxt = 1'b0, key_run = 1'b0, key_flip = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0;
  logic [15:0] rate = 16'd0;
  logic [7:0]  row, col;
  logic        busy, stable;
  logic [15:0] gen_cnt;

  typedef struct {
    logic [63:0] grid;
    logic [63:0] mask;
    logic [15:0] gen;
    logic        stable;
    int          period;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   cx = 0, cy = 0;

  life_gen_engine #(.SCAN_W(2)) dut (
    .clk(clk), .reset(reset),
    .key_nxt(key_nxt), .key_run(key_run), .key_flip(key_flip),
    .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right),
    .rate(rate), .row(row), .col(col),
    .busy(busy), .stable(stable), .gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset)    busy_run = 0;
    else if (busy) busy_run = busy_run + 1;
  end

  function automatic logic [63:0] cb(input int x, input int y);
    logic [63:0] r;
    r = '0;
    r[y * 8 + x] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic capture(output logic [63:0] g, output bit ok);
    logic [7:0] seen;
    seen = '0;
    g = '0;
    for (int n = 0; n < 64 && seen != 8'hff; n++) begin
      @(negedge clk);
      for (int l = 0; l < 8; l++)
        if (col == (8'd1 << l)) begin
          g[l*8 +: 8] = row;
          seen[l] = 1'b1;
        end
    end
    ok = (seen == 8'hff);
  endtask

  task automatic check_grid(input string name, input logic [63:0] req,
                            input logic [63:0] mask);
    logic [63:0] g;
    bit ok;
    capture(g, ok);
    if (!ok) begin
      total++;
      $display("FAIL %s: scan incomplete, required %h", name, req);
    end else begin
      check(name, g & ~mask, req & ~mask);
    end
  endtask

  task automatic push(input logic [63:0] g, input int gen,
                      input logic st, input int period);
    exp_t e;
    e.grid = g;
    e.mask = cb(cx, cy);
    e.gen = 16'(gen);
    e.stable = st;
    e.period = period;
    sbq.push_back(e);
  endtask

  // k: 0 nxt 1 run 2 flip 3 up 4 down 5 left 6 right
  task automatic press(input int k);
    @(negedge clk);
    case (k)
      0: key_nxt = 1'b1;
      1: key_run = 1'b1;
      2: key_flip = 1'b1;
      3: begin key_up = 1'b1; cy = (cy + 7) % 8; end
      4: begin key_down = 1'b1; cy = (cy + 1) % 8; end
      5: begin key_left = 1'b1; cx = (cx + 7) % 8; end
      6: begin key_right = 1'b1; cx = (cx + 1) % 8; end
      default: ;
    endcase
    @(negedge clk);
    {key_nxt, key_run, key_flip, key_up, key_down, key_left, key_right} = '0;
    @(negedge clk);
  endtask

  task automatic move(input int k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cx = 0;
    cy = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_gen();
    int n;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    if (!busy) begin
      total++;
      $display("FAIL start_timeout: busy=%b, required 1", busy);
    end
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      total++;
      $display("FAIL end_timeout: busy=%b, required 0", busy);
    end
    repeat (45) @(negedge clk);
  endtask

  // Monitor: each new generation is checked against the scoreboard head.
  initial begin : monitor
    logic [15:0] prev;
    int last;
    exp_t e;
    prev = '0;
    last = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = gen_cnt;
      end else if (gen_cnt != prev) begin
        prev = gen_cnt;
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_gen: gen_cnt=%0d, required no step",
                   gen_cnt);
          last = cyc;
        end else begin
          e = sbq.pop_front();
          check("gen_cnt", 64'(gen_cnt), 64'(e.gen));
          check("stable", 64'(stable), 64'(e.stable));
          check("busy_len", 64'(busy_run), 64'd65);
          if (e.period != 0)
            check("period", 64'(cyc - last), 64'(e.period));
          last = cyc;
          busy_run = 0;
          check_grid("gen_grid", e.grid, e.mask);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] hb, vb, blk, e3, e4;
    int n;
    hb  = cb(0,3) | cb(1,3) | cb(2,3);
    vb  = cb(1,2) | cb(1,3) | cb(1,4);
    blk = cb(3,3) | cb(4,3) | cb(3,4) | cb(4,4);
`ifdef LIFE_TORUS_EN
    e3 = cb(7,3) | cb(0,3) | cb(1,3);
    e4 = cb(0,2) | cb(0,3) | cb(0,4);
`else
    e3 = cb(0,3) | cb(1,3);
    e4 = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gen", 64'(gen_cnt), 64'd0);
    check("rst_stable", 64'(stable), 64'd0);
    check("rst_row", 64'(row), 64'd0);
    check("rst_col", 64'(col), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // blinker: edit, step twice
    move(4, 3); press(2);
    move(6, 1); press(2);
    move(6, 1); press(2);
    move(5, 3); move(3, 4);
    check_grid("edit_grid", hb, cb(cx, cy));
    push(vb, 1, 1'b0, 0);
    press(0);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("step_latency", 64'(n), 64'd1);
    wait_gen();
    push(hb, 2, 1'b0, 0);
    press(0);
    wait_gen();

    // block under auto-run stops itself
    do_reset();
    move(4, 3); move(6, 3); press(2);
    move(6, 1); press(2);
    move(4, 1); press(2);
    move(5, 1); press(2);
    move(5, 4); move(4, 3);
    rate = 16'd0;
    push(blk, 1, 1'b1, 0);
    press(1);
    wait_gen();
    n = 0;
    repeat (200) begin @(negedge clk); if (busy) n++; end
    check("run_stopped", 64'(n), 64'd0);
    check("hold_gen", 64'(gen_cnt), 64'd1);

    // vertical line at the left edge
    do_reset();
    move(4, 2); press(2);
    move(4, 1); press(2);
    move(4, 1); press(2);
    move(5, 1); move(4, 3);
    push(e3, 1, 1'b0, 0);
    press(0);
    wait_gen();

    // flip and step presses during CALC are dropped
    move(5, 5); move(3, 4);
    push(e4, 2, 1'b0, 0);
    press(0);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    press(2);
    press(0);
    wait_gen();

    // auto-run blinker, then reset mid-CALC
    do_reset();
    move(4, 3); press(2);
    move(6, 1); press(2);
    move(6, 1); press(2);
    move(5, 3); move(3, 4);
    rate = 16'd3;
    push(vb, 1, 1'b0, 0);
    push(hb, 2, 1'b0, 70);
    push(vb, 3, 1'b0, 70);
    press(1);
    n = 0;
    while (gen_cnt != 16'd3 && n < 400) begin @(negedge clk); n++; end
    check("run_gen3", 64'(gen_cnt), 64'd3);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    cx = 0;
    cy = 0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_gen", 64'(gen_cnt), 64'd0);
    check("abort_row", 64'(row), 64'd0);
    check("abort_col", 64'(col), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_grid("abort_grid", 64'd0, cb(cx, cy));
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
Parametrised Game-of-Life generation engine, successor to the fixed 8x8 life top. It holds an X by Y grid with programmable birth/survive rules, cursor editing, single-step and auto-run stepping, and a multiplexed LED scan. Next-generation cells are computed serially, one per clock, into a shadow grid, then committed atomically. It sits between the debounced key inputs and the LED matrix row/col drivers.

Parameters:
X, 8, grid width (cells per line), >=3
Y, 8, grid height (lines), >=3
LOG2X, 3, ceil(log2(X))
LOG2Y, 3, ceil(log2(Y))
BIRTH, 9'b000001000, bit n=1: dead cell with n live neighbours is born
SURVIVE, 9'b000001100, bit n=1: live cell with n live neighbours survives
TICK_W, 16, auto-run prescaler width
SCAN_W, 10, display dwell counter width per line

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
key_nxt  in  1  single-step request (debounced level)
key_run  in  1  toggle auto-run (debounced level)
key_flip  in  1  toggle cell under cursor
key_up, key_down, key_left, key_right  in  1 each  cursor moves
rate  in  TICK_W  auto-run idle interval
row  out  X  cell data of the scanned line, active-high
col  out  Y  one-hot line select, active-high
busy  out  1  generation in progress
stable  out  1  last commit left the grid unchanged
gen_cnt  out  16  generation counter

Behaviour:
- Reset (reset=0, async): grid=0, shadow=0, cursor=(0,0), run=0, step_pend=0, prescaler=0, state IDLE, gen_cnt=0, stable=0, busy=0, row=0, col=0, key history=0. Reset mid-CALC aborts; no partial commit.
- Keys: press = rising edge (key & ~key_d, key_d registered). A key held through reset yields one press after release.
- Cell index i=y*X+x; cursor x in 0..X-1, y in 0..Y-1; moves wrap (right at X-1 -> 0, up at 0 -> Y-1, etc.), allowed in any state.
- FSM IDLE -> CALC -> COMMIT -> IDLE; busy = (state != IDLE).
- IDLE: a flip press toggles grid[cursor] that cycle; flip presses outside IDLE are dropped. A key_nxt press or prescaler tick sets step_pend. IDLE->CALC when step_pend=1 and no flip press that cycle; step_pend clears on entry.
- CALC: counter 0..X*Y-1, one cell per clock; neighbour sum (0..8) taken from the unchanged grid; shadow[i] = grid[i] ? SURVIVE[sum] : BIRTH[sum]. After X*Y cycles -> COMMIT.
- COMMIT (1 cycle): grid<=shadow; gen_cnt+1 (wraps 0xFFFF->0); stable<=(shadow==grid); if stable and run, run<=0.
- key_nxt and key_run presses while busy: key_nxt dropped; key_run toggles run immediately.
- Auto-run: prescaler counts only while run=1, IDLE, step_pend=0; at value==rate sets step_pend and clears. rate=0 -> step every other idle cycle. Generation period = X*Y+rate+3 clocks. Tick and key_nxt in the same cycle = one step.
- Latency: key_nxt press sampled at edge k -> busy=1 after edge k+2 -> grid updates at edge k+X*Y+3.
- Display: dwell counter SCAN_W bits; on wrap, line advances 0..Y-1 cyclically; frame counter (5 bits) advances per full frame; blink = its MSB. Registered outputs: col=one-hot(line), row=grid line bits, cursor cell XORed with blink when cursor is on that line. Display runs in all states and shows the committed grid only.

Optional Feature:
LIFE_TORUS_EN defined: neighbour coordinates wrap modulo X and Y (toroidal grid). Not defined: out-of-grid neighbours count as dead.

Test Plan:
- 8x8, flip (0,3),(1,3),(2,3), key_nxt -> busy for 65 cycles, grid (1,2),(1,3),(1,4), gen_cnt=1, stable=0; second step restores original, gen_cnt=2.
- 2x2 block at (3,3), run=1, rate=0 -> after first commit stable=1, run=0, gen_cnt=1, no further steps.
- Vertical line (0,2),(0,3),(0,4), one step -> without LIFE_TORUS_EN cells (0,3),(1,3); with it (7,3),(0,3),(1,3).
- key_flip and key_nxt pulsed mid-CALC -> grid unaffected by flip, gen_cnt rises by exactly 1.
- run=1, rate=3, blinker -> gen_cnt increments every 70 cycles; assert reset mid-CALC -> grid=0, busy=0, gen_cnt=0 immediately.
